// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Write-side companion to the instruction memory. Consumes a framed byte
// stream from a host link (SYNC_BYTE, word count N, then 4*N bytes, MSB
// first), assembles big-endian 32-bit words and writes them sequentially
// into the instruction memory starting at word 0. The processor is held in
// reset through cpu_hold while a frame is being loaded.
//
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   in_data      - stream byte
//   in_valid     - in_data valid
//   in_ready     - loader can accept a byte (transfer on valid && ready)
//   mem_we       - one-cycle write strobe to instruction memory
//   mem_addr     - word address of the write
//   mem_wdata    - assembled instruction word
//   cpu_hold     - high while a load is in progress
//   load_done    - one-cycle pulse when a frame completes
//   load_err     - sticky error (word count larger than DEPTH)
//   word_count   - words written in the current or last frame
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int           DEPTH     = 128,
  parameter int           AW        = 7,
  parameter logic [7:0]   SYNC_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE
  } state_t;

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic [AW:0] n_words;
  logic [AW:0] count_q;
  logic [AW:0] count_inc;
  logic [1:0]  byte_pos;
  logic [31:0] shift_q;
  logic        hold_q;
  logic        err_q;
  logic        len_too_big;

  assign accept      = in_valid && in_ready;
  assign count_inc   = count_q + (AW+1)'(1);
  assign len_too_big = ({1'b0, in_data} > DEPTH_W);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode. WRITE always lasts exactly one cycle, which is the
  // single bubble per word seen on the input side.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept && in_data == SYNC_BYTE) next_state = LEN;
      LEN: begin
        if (accept) begin
          if (in_data == 8'd0)  next_state = DONE;
          else if (len_too_big) next_state = IDLE;
          else                  next_state = DATA;
        end
      end
      DATA:  if (accept && byte_pos == 2'd3) next_state = WRITE;
      WRITE: next_state = (count_inc == n_words) ? DONE : DATA;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: frame length, byte assembly, word counter and the hold/error
  // flags. byte_pos wraps naturally after the fourth byte of each word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_words  <= '0;
      count_q  <= '0;
      byte_pos <= '0;
      shift_q  <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && in_data == SYNC_BYTE) begin
            hold_q   <= 1'b1;
            err_q    <= 1'b0;
            count_q  <= '0;
            byte_pos <= '0;
          end
        end
        LEN: begin
          if (accept && in_data != 8'd0) begin
            if (len_too_big) begin
              err_q  <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              n_words <= (AW+1)'(in_data);
            end
          end
        end
        DATA: begin
          if (accept) begin
            shift_q  <= {shift_q[23:0], in_data};
            byte_pos <= byte_pos + 2'd1;
          end
        end
        WRITE: count_q <= count_inc;
        DONE:  hold_q  <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state so they only move on a clock
  // edge or on reset.
  assign in_ready   = (state == IDLE) || (state == LEN) || (state == DATA);
  assign mem_we     = (state == WRITE);
  assign mem_addr   = count_q[AW-1:0];
  assign mem_wdata  = shift_q;
  assign load_done  = (state == DONE);
  assign cpu_hold   = hold_q;
  assign load_err   = err_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Frames are built into a byte queue,
// driven through the valid/ready handshake (optionally with random gaps),
// and the writes captured from the memory port are compared with a model
// that decodes the same byte queue directly into expected words.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  typedef logic [7:0] u8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [7:0]  word_count;

  int vectors;
  int miscompares;

  u8           frameQ[$];
  logic [6:0]  obsAddr[$];
  logic [31:0] obsData[$];
  int          doneCnt;
  int          viol;

  logic [31:0] expWords[$];
  int          expDone;
  logic        expErr;
  int          expCount;

  imem_loader #(.DEPTH(128), .AW(7), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_err(load_err),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture memory-port activity at the falling edge, away from the active
  // edge. Illegal overlaps are tallied and compared at the end of each frame.
  always @(negedge clk) begin
    if (mem_we) begin
      obsAddr.push_back(mem_addr);
      obsData.push_back(mem_wdata);
      if (in_ready)  viol++;
      if (load_done) viol++;
      if (!cpu_hold) viol++;
    end
    if (load_done) doneCnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it. Optional random
  // idle cycles with junk data precede the byte.
  task automatic applyStimulus(input u8 b, input bit gaps);
    int guard;
    guard = 0;
    @(negedge clk);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("in_ready_timeout", 64'(guard), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic clearObs();
    obsAddr.delete();
    obsData.delete();
    doneCnt = 0;
    viol    = 0;
  endtask

  // Reference model: find the sync byte, read N, then take 4*N bytes as
  // big-endian words. An oversize N is an error with no writes.
  task automatic buildModel();
    int i;
    int n;
    expWords.delete();
    expDone  = 0;
    expErr   = 1'b0;
    expCount = 0;
    i = 0;
    while (i < frameQ.size() && frameQ[i] != 8'hA5) i++;
    i++;
    n = int'(frameQ[i]);
    i++;
    if (n > 128) begin
      expErr = 1'b1;
    end else begin
      for (int w = 0; w < n; w++) begin
        expWords.push_back({frameQ[i+4*w], frameQ[i+4*w+1],
                            frameQ[i+4*w+2], frameQ[i+4*w+3]});
      end
      expDone  = 1;
      expCount = n;
    end
  endtask

  task automatic sendFrom(input int first, input bit gaps);
    for (int i = first; i < frameQ.size(); i++) applyStimulus(frameQ[i], gaps);
  endtask

  task automatic checkFrame(input string tag);
    repeat (4) @(negedge clk);
    buildModel();
    checkOutput({tag, "_nwrites"}, 64'(obsData.size()), 64'(expWords.size()));
    for (int w = 0; w < expWords.size() && w < obsData.size(); w++) begin
      checkOutput($sformatf("%s_addr%0d", tag, w), 64'(obsAddr[w]), 64'(w));
      checkOutput($sformatf("%s_data%0d", tag, w), 64'(obsData[w]), 64'(expWords[w]));
    end
    checkOutput({tag, "_done"},  64'(doneCnt),    64'(expDone));
    checkOutput({tag, "_err"},   64'(load_err),   64'(expErr));
    checkOutput({tag, "_count"}, 64'(word_count), 64'(expCount));
    checkOutput({tag, "_hold"},  64'(cpu_hold),   64'd0);
    checkOutput({tag, "_ready"}, 64'(in_ready),   64'd1);
    checkOutput({tag, "_viol"},  64'(viol),       64'd0);
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    clearObs();
    repeat (3) @(negedge clk);
    checkOutput("reset_state",
                64'({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold,
                     load_done, load_err, word_count}),
                64'({1'b1, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0}));
    rst_n = 1'b1;

    // Two-word frame, no gaps; hold must rise right after the sync byte.
    frameQ = '{8'hA5, 8'h02, 8'h01, 8'hCE, 8'h70, 8'h22,
               8'h01, 8'hEF, 8'h78, 8'h22};
    clearObs();
    applyStimulus(frameQ[0], 1'b0);
    checkOutput("basic_hold_after_sync", 64'(cpu_hold), 64'd1);
    sendFrom(1, 1'b0);
    checkFrame("basic");

    // Leading garbage is dropped.
    frameQ = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clearObs();
    sendFrom(0, 1'b0);
    checkFrame("garbage");

    // Oversize length, then an empty frame that clears the error.
    frameQ = '{8'hA5, 8'h81};
    clearObs();
    sendFrom(0, 1'b0);
    checkFrame("oversize");
    frameQ = '{8'hA5, 8'h00};
    clearObs();
    sendFrom(0, 1'b0);
    checkFrame("empty");

    // Full-depth frame with random payload.
    frameQ = '{8'hA5, 8'h80};
    for (int i = 0; i < 512; i++) frameQ.push_back(8'($urandom));
    clearObs();
    sendFrom(0, 1'b0);
    checkFrame("full");

    // Same two-word frame with random valid gaps.
    frameQ = '{8'hA5, 8'h02, 8'h01, 8'hCE, 8'h70, 8'h22,
               8'h01, 8'hEF, 8'h78, 8'h22};
    clearObs();
    sendFrom(0, 1'b1);
    checkFrame("gaps");

    // Random-length frames with random payload and gaps.
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 6);
      frameQ = '{8'hA5, 8'(n)};
      for (int i = 0; i < 4 * n; i++) frameQ.push_back(8'($urandom));
      clearObs();
      sendFrom(0, 1'b1);
      checkFrame($sformatf("rand%0d", f));
    end

    // Reset in the middle of the second word of a two-word frame.
    frameQ = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    clearObs();
    sendFrom(0, 1'b0);
    checkOutput("midreset_pre_hold", 64'(cpu_hold), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_outputs",
                64'({mem_we, mem_addr, mem_wdata, cpu_hold,
                     load_done, load_err, word_count}),
                64'd0);
    checkOutput("midreset_first_word", 64'(obsData.size() > 0 ? obsData[0] : 32'hX),
                64'h12345678);
    @(negedge clk);
    rst_n = 1'b1;
    frameQ = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    clearObs();
    sendFrom(0, 1'b0);
    checkFrame("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
